nfc_cmd_addr_seq: RTL and testbench
===================================

Name: nfc_cmd_addr_seq

Overview:
Command/address bus sequencer sitting directly downstream of the NFC SFR block. It consumes the latched command, control, timing and address registers. On each nf_cmd_valid pulse it drives one NAND command-latch cycle, then, if enabled, the column and row address-latch cycles on the 8-bit NAND bus. When the address phase completes it returns addr_clear to the SFR block so that nf_addr_en self-clears. The data phase is handled by a separate block.

Parameters:
MAX_ADDR_BYTES, 4, maximum bytes per address field; larger programmed counts are clamped to this value.
IDLE_CEB, 4'hF, value driven on nf_ceb_o while the sequencer is idle.

Ports:
nfc_clk  in  1  block clock
rst_nfc  in  1  synchronous, active-high reset
nf_cmd  in  8  command byte
nf_cmd_valid  in  1  one-cycle start pulse
nf_addr_en  in  1  address phase follows the command
nf_ceb  in  4  chip-enable pattern, active low
nf_total_cycle  in  3  bus-cycle length control
nf_high_cycle  in  4  WE# high-phase length
nf_column_addr_cnt  in  3  number of column address bytes
nf_row_addr_cnt  in  3  number of row address bytes
nf_column_addr  in  32  column address, byte 0 in bits [7:0]
nf_row_addr  in  32  row address, byte 0 in bits [7:0]
nf_io_o  out  8  NAND IO output data
nf_io_oe  out  1  NAND IO output enable
nf_cle  out  1  command latch enable
nf_ale  out  1  address latch enable
nf_web  out  1  write enable, active low
nf_ceb_o  out  4  chip enables to the pads
addr_clear  out  1  one-cycle pulse; clears nf_addr_en
seq_busy  out  1  high while a sequence is in progress
cmd_err  out  1  one-cycle pulse when nf_cmd_valid arrives while busy

Behaviour:
- Single clock domain (nfc_clk). rst_nfc is synchronous and active-high; it is sampled only on the rising edge of nfc_clk.
- Reset values: nf_io_o=0, nf_io_oe=0, nf_cle=0, nf_ale=0, nf_web=1, nf_ceb_o=IDLE_CEB, addr_clear=0, seq_busy=0, cmd_err=0. State returns to IDLE.
- Reset asserted mid-sequence aborts the sequence at the next edge and forces all outputs to their reset values. No addr_clear pulse is generated.
- States: IDLE -> CMD -> COL -> ROW -> DONE -> IDLE.
- IDLE:
  - On nf_cmd_valid, capture into a snapshot: nf_cmd, nf_addr_en, nf_ceb, the timing fields, both address counts (each clamped to MAX_ADDR_BYTES) and both addresses.
  - Next state is CMD and seq_busy goes high on that same edge.
  - SFR changes made mid-sequence do not affect the sequence in progress.
- Bus-cycle timing:
  - Bus-cycle length L = nf_total_cycle + 2 clocks, giving 2 to 9.
  - High-phase length H = clamp(nf_high_cycle, 1, L-1).
  - nf_web is low for the first L-H clocks of each bus cycle and high for the last H clocks.
  - nf_io_o, nf_cle and nf_ale are stable for the whole bus cycle, so data is valid at the WE# rising edge.
- CMD: one bus cycle with nf_cle=1, nf_ale=0 and nf_io_o=cmd byte.
  - At the end, go to COL if addr_en is set and col_cnt is nonzero.
  - Otherwise go to ROW if addr_en is set and row_cnt is nonzero.
  - Otherwise go to DONE.
- COL: col_cnt bus cycles with nf_ale=1 and nf_cle=0. Bytes are sent low byte first: nf_column_addr[7:0], then [15:8], and so on. At the end, go to ROW if row_cnt is nonzero, else DONE.
- ROW: same as COL, using the row address and row_cnt. Then go to DONE.
- Consecutive bus cycles are back-to-back, with no idle clock between them.
- DONE: lasts one clock.
  - nf_cle=0, nf_ale=0, nf_io_oe=0, nf_web=1.
  - addr_clear=1 only if the captured addr_en was 1.
  - Next state is IDLE; seq_busy falls on the following edge.
- nf_io_oe=1 in CMD, COL and ROW; 0 otherwise.
- nf_ceb_o = captured ceb while seq_busy is high; IDLE_CEB otherwise.
- nf_cmd_valid while not in IDLE: the pulse is ignored and cmd_err pulses for one cycle.
- nf_cmd_valid in the same cycle that DONE is left is also ignored and flagged as cmd_err.
- Total latency from the nf_cmd_valid edge to the addr_clear pulse = (1 + col_cnt + row_cnt) × L + 1 clocks.

Decomposition:
- Package nfc_seq_pkg holds:
  - the state enum (IDLE, CMD, COL, ROW, DONE);
  - the MAX_ADDR_BYTES default;
  - a byte-count clamp function;
  - the function computing L and H from the timing fields.
- Sub-module nfc_we_timer:
  - takes a start pulse plus L and H;
  - produces nf_web and a cycle_done pulse on the last clock of each bus cycle;
  - the sequencer FSM advances on cycle_done.

Test Plan:
- Reset, then idle: outputs equal the reset values; nf_ceb_o=4'hF; seq_busy=0.
- nf_cmd=8'h70, addr_en=0, total=0, high=1 -> one CLE cycle of 2 clocks; nf_web low 1 clock, then high 1 clock; no addr_clear; seq_busy spans 3 clocks.
- nf_cmd=8'h00, addr_en=1, col_cnt=2, row_cnt=3, column=32'h0000_0800, row=32'h0001_2345, total=3, high=2, nf_ceb=4'b1110 ->
  - bus sequence: CLE 00, then ALE 00, 08, 45, 23, 01;
  - each bus cycle is 5 clocks, with nf_web low 3 and high 2;
  - addr_clear pulses 31 clocks after the start;
  - nf_ceb_o=4'b1110 throughout.
- col_cnt=7, row_cnt=0, addr_en=1 -> exactly 4 ALE bytes (clamp to MAX_ADDR_BYTES); then addr_clear.
- Second nf_cmd_valid mid-sequence, and SFR address rewritten mid-sequence -> cmd_err pulse; the output byte sequence is unchanged from the first command.
- rst_nfc asserted during the ROW phase -> next edge: outputs at reset values; no addr_clear; a new command afterwards runs normally.

Source files
------------

// File: rtl/nfc_seq_pkg.sv
// Shared types and helpers for the NAND command/address bus sequencer.
package nfc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    COL  = 3'd2,
    ROW  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam int MAX_ADDR_BYTES_DEF = 4;

  // Bus-cycle length (l_len) and WE# high-phase length (h_len), in clocks.
  typedef struct packed {
    logic [3:0] l_len;
    logic [3:0] h_len;
  } bus_timing_t;

  // Limit a programmed address byte count to what the address field can hold.
  function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt, input int max_bytes);
    if (int'(cnt) > max_bytes) return 3'(max_bytes);
    return cnt;
  endfunction

  // L = total + 2 (2..9); H = high clamped into 1..L-1 so WE# always has a low phase.
  function automatic bus_timing_t calc_timing(input logic [2:0] total, input logic [3:0] high);
    bus_timing_t t;
    t.l_len = {1'b0, total} + 4'd2;
    if (high == 4'd0)                    t.h_len = 4'd1;
    else if (high > (t.l_len - 4'd1))    t.h_len = t.l_len - 4'd1;
    else                                 t.h_len = high;
    return t;
  endfunction

  // Address bytes go out low byte first.
  function automatic logic [7:0] addr_byte(input logic [31:0] a, input logic [2:0] idx);
    case (idx)
      3'd0:    return a[7:0];
      3'd1:    return a[15:8];
      3'd2:    return a[23:16];
      default: return a[31:24];
    endcase
  endfunction

endpackage

// File: rtl/nfc_we_timer.sv
// Times one NAND bus cycle: WE# low for L-H clocks then high for H clocks.
// cycle_done is high during the last clock so the next cycle can start back-to-back.
module nfc_we_timer (
  input  logic       nfc_clk,
  input  logic       rst_nfc,
  input  logic       start,
  input  logic [3:0] l_len,
  input  logic [3:0] h_len,
  output logic       nf_web,
  output logic       cycle_done
);

  logic [3:0] cnt;
  logic [3:0] l_q;
  logic [3:0] low_q;
  logic       active;

  assign cycle_done = active && (cnt == (l_q - 4'd1));

  // Bus-cycle counter; a start always wins so consecutive cycles abut.
  always_ff @(posedge nfc_clk) begin
    if (rst_nfc) begin
      cnt    <= 4'd0;
      l_q    <= 4'd2;
      low_q  <= 4'd1;
      active <= 1'b0;
      nf_web <= 1'b1;
    end else if (start) begin
      cnt    <= 4'd0;
      l_q    <= l_len;
      low_q  <= l_len - h_len;
      active <= 1'b1;
      nf_web <= 1'b0;
    end else if (active) begin
      if (cycle_done) begin
        cnt    <= 4'd0;
        active <= 1'b0;
        nf_web <= 1'b1;
      end else begin
        cnt    <= cnt + 4'd1;
        nf_web <= ((cnt + 4'd1) >= low_q);
      end
    end
  end

endmodule

// File: rtl/nfc_cmd_addr_seq.sv
// NAND command/address sequencer: one CLE cycle, then optional column and row
// ALE cycles, then a one-clock DONE that returns addr_clear to the SFR block.
//
// Handshake: nf_cmd_valid is a one-cycle request with no ready signal. The
// request is accepted only when the sequencer is IDLE (seq_busy low); a request
// seen in any other state is dropped and reported by a one-cycle cmd_err.
module nfc_cmd_addr_seq
  import nfc_seq_pkg::*;
#(
  parameter int         MAX_ADDR_BYTES = MAX_ADDR_BYTES_DEF,
  parameter logic [3:0] IDLE_CEB       = 4'hF
) (
  input  logic        nfc_clk,
  input  logic        rst_nfc,
  input  logic [7:0]  nf_cmd,
  input  logic        nf_cmd_valid,
  input  logic        nf_addr_en,
  input  logic [3:0]  nf_ceb,
  input  logic [2:0]  nf_total_cycle,
  input  logic [3:0]  nf_high_cycle,
  input  logic [2:0]  nf_column_addr_cnt,
  input  logic [2:0]  nf_row_addr_cnt,
  input  logic [31:0] nf_column_addr,
  input  logic [31:0] nf_row_addr,
  output logic [7:0]  nf_io_o,
  output logic        nf_io_oe,
  output logic        nf_cle,
  output logic        nf_ale,
  output logic        nf_web,
  output logic [3:0]  nf_ceb_o,
  output logic        addr_clear,
  output logic        seq_busy,
  output logic        cmd_err,
  output seq_state_t  dbg_state
);

  seq_state_t  state;
  bus_timing_t live_tim, s_tim, tim_sel;
  logic        s_addr_en;
  logic [2:0]  s_col_cnt, s_row_cnt, byte_idx;
  logic [31:0] s_col_addr, s_row_addr;
  logic        cycle_done, timer_start;
  logic        cmd_to_col, cmd_to_row, col_more, row_more;

  assign dbg_state  = state;
  assign live_tim   = calc_timing(nf_total_cycle, nf_high_cycle);
  // The first cycle starts from IDLE before the snapshot exists, so use live timing there.
  assign tim_sel    = (state == IDLE) ? live_tim : s_tim;
  assign cmd_to_col = s_addr_en && (s_col_cnt != 3'd0);
  assign cmd_to_row = s_addr_en && (s_row_cnt != 3'd0);
  assign col_more   = byte_idx != (s_col_cnt - 3'd1);
  assign row_more   = byte_idx != (s_row_cnt - 3'd1);

  // Start the bus-cycle timer whenever the FSM enters or stays in a bus phase.
  always_comb begin
    timer_start = 1'b0;
    case (state)
      IDLE:    timer_start = nf_cmd_valid;
      CMD:     timer_start = cycle_done && (cmd_to_col || cmd_to_row);
      COL:     timer_start = cycle_done && (col_more || (s_row_cnt != 3'd0));
      ROW:     timer_start = cycle_done && row_more;
      default: timer_start = 1'b0;
    endcase
  end

  nfc_we_timer u_we_timer (
    .nfc_clk    (nfc_clk),
    .rst_nfc    (rst_nfc),
    .start      (timer_start),
    .l_len      (tim_sel.l_len),
    .h_len      (tim_sel.h_len),
    .nf_web     (nf_web),
    .cycle_done (cycle_done)
  );

  // Sequencer FSM with registered bus outputs.
  always_ff @(posedge nfc_clk) begin
    if (rst_nfc) begin
      state      <= IDLE;
      s_addr_en  <= 1'b0;
      s_tim      <= '0;
      s_col_cnt  <= 3'd0;
      s_row_cnt  <= 3'd0;
      s_col_addr <= 32'd0;
      s_row_addr <= 32'd0;
      byte_idx   <= 3'd0;
      nf_io_o    <= 8'd0;
      nf_io_oe   <= 1'b0;
      nf_cle     <= 1'b0;
      nf_ale     <= 1'b0;
      nf_ceb_o   <= IDLE_CEB;
      addr_clear <= 1'b0;
      seq_busy   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err    <= nf_cmd_valid && (state != IDLE);
      addr_clear <= 1'b0;
      case (state)
        IDLE: if (nf_cmd_valid) begin
          s_addr_en  <= nf_addr_en;
          s_tim      <= live_tim;
          s_col_cnt  <= clamp_cnt(nf_column_addr_cnt, MAX_ADDR_BYTES);
          s_row_cnt  <= clamp_cnt(nf_row_addr_cnt, MAX_ADDR_BYTES);
          s_col_addr <= nf_column_addr;
          s_row_addr <= nf_row_addr;
          byte_idx   <= 3'd0;
          nf_ceb_o   <= nf_ceb;
          nf_io_o    <= nf_cmd;
          nf_io_oe   <= 1'b1;
          nf_cle     <= 1'b1;
          nf_ale     <= 1'b0;
          seq_busy   <= 1'b1;
          state      <= CMD;
        end
        CMD: if (cycle_done) begin
          nf_cle   <= 1'b0;
          byte_idx <= 3'd0;
          if (cmd_to_col) begin
            state   <= COL;
            nf_ale  <= 1'b1;
            nf_io_o <= addr_byte(s_col_addr, 3'd0);
          end else if (cmd_to_row) begin
            state   <= ROW;
            nf_ale  <= 1'b1;
            nf_io_o <= addr_byte(s_row_addr, 3'd0);
          end else begin
            state      <= DONE;
            nf_io_o    <= 8'd0;
            nf_io_oe   <= 1'b0;
            addr_clear <= s_addr_en;
          end
        end
        COL: if (cycle_done) begin
          if (col_more) begin
            byte_idx <= byte_idx + 3'd1;
            nf_io_o  <= addr_byte(s_col_addr, byte_idx + 3'd1);
          end else if (s_row_cnt != 3'd0) begin
            state    <= ROW;
            byte_idx <= 3'd0;
            nf_io_o  <= addr_byte(s_row_addr, 3'd0);
          end else begin
            state      <= DONE;
            nf_ale     <= 1'b0;
            nf_io_o    <= 8'd0;
            nf_io_oe   <= 1'b0;
            addr_clear <= s_addr_en;
          end
        end
        ROW: if (cycle_done) begin
          if (row_more) begin
            byte_idx <= byte_idx + 3'd1;
            nf_io_o  <= addr_byte(s_row_addr, byte_idx + 3'd1);
          end else begin
            state      <= DONE;
            nf_ale     <= 1'b0;
            nf_io_o    <= 8'd0;
            nf_io_oe   <= 1'b0;
            addr_clear <= s_addr_en;
          end
        end
        DONE: begin
          state    <= IDLE;
          seq_busy <= 1'b0;
          nf_ceb_o <= IDLE_CEB;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_cmd_addr_seq.sv
// Directed testbench for nfc_cmd_addr_seq.
module tb_nfc_cmd_addr_seq;
  import nfc_seq_pkg::*;

  logic        nfc_clk = 1'b0;
  logic        rst_nfc;
  logic [7:0]  nf_cmd;
  logic        nf_cmd_valid;
  logic        nf_addr_en;
  logic [3:0]  nf_ceb;
  logic [2:0]  nf_total_cycle;
  logic [3:0]  nf_high_cycle;
  logic [2:0]  nf_column_addr_cnt;
  logic [2:0]  nf_row_addr_cnt;
  logic [31:0] nf_column_addr;
  logic [31:0] nf_row_addr;
  logic [7:0]  nf_io_o;
  logic        nf_io_oe, nf_cle, nf_ale, nf_web;
  logic [3:0]  nf_ceb_o;
  logic        addr_clear, seq_busy, cmd_err;
  seq_state_t  dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int          e0;
  logic [3:0]  exp_ceb;

  // Clock and edge counter
  always #5 nfc_clk = ~nfc_clk;
  always @(posedge nfc_clk) edge_cnt++;

  nfc_cmd_addr_seq dut (
    .nfc_clk            (nfc_clk),
    .rst_nfc            (rst_nfc),
    .nf_cmd             (nf_cmd),
    .nf_cmd_valid       (nf_cmd_valid),
    .nf_addr_en         (nf_addr_en),
    .nf_ceb             (nf_ceb),
    .nf_total_cycle     (nf_total_cycle),
    .nf_high_cycle      (nf_high_cycle),
    .nf_column_addr_cnt (nf_column_addr_cnt),
    .nf_row_addr_cnt    (nf_row_addr_cnt),
    .nf_column_addr     (nf_column_addr),
    .nf_row_addr        (nf_row_addr),
    .nf_io_o            (nf_io_o),
    .nf_io_oe           (nf_io_oe),
    .nf_cle             (nf_cle),
    .nf_ale             (nf_ale),
    .nf_web             (nf_web),
    .nf_ceb_o           (nf_ceb_o),
    .addr_clear         (addr_clear),
    .seq_busy           (seq_busy),
    .cmd_err            (cmd_err),
    .dbg_state          (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view of the bus outputs: {cle, ale, oe, web, busy, addr_clear, ceb, io}
  function automatic logic [31:0] bus_vec();
    return 32'({nf_cle, nf_ale, nf_io_oe, nf_web, seq_busy, addr_clear, nf_ceb_o, nf_io_o});
  endfunction

  function automatic logic [31:0] mk_vec(input logic cle, ale, oe, web, busy, ac,
                                         input logic [3:0] ceb, input logic [7:0] io);
    return 32'({cle, ale, oe, web, busy, ac, ceb, io});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_bus"}, bus_vec(), mk_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'h00));
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Driver: present one command for a single clock.
  task automatic start_cmd(input logic [7:0] cmd, input logic aen, input logic [3:0] ceb,
                           input logic [2:0] total, input logic [3:0] high,
                           input logic [2:0] colc, input logic [2:0] rowc,
                           input logic [31:0] cola, input logic [31:0] rowa);
    nf_cmd = cmd; nf_addr_en = aen; nf_ceb = ceb;
    nf_total_cycle = total; nf_high_cycle = high;
    nf_column_addr_cnt = colc; nf_row_addr_cnt = rowc;
    nf_column_addr = cola; nf_row_addr = rowa;
    exp_ceb = ceb;
    nf_cmd_valid = 1'b1;
    @(negedge nfc_clk);
    nf_cmd_valid = 1'b0;
  endtask

  // Check one bus cycle clock by clock; optionally inject a second command and SFR rewrite.
  task automatic bus_cycle(input string tag, input logic cle, input logic ale,
                           input logic [7:0] data, input int l, input int h, input bit inject);
    for (int i = 0; i < l; i++) begin
      check(tag, bus_vec(), mk_vec(cle, ale, 1'b1, (i < l - h) ? 1'b0 : 1'b1, 1'b1, 1'b0, exp_ceb, data));
      if (inject && i == 1) begin
        check({tag, "_cmd_err"}, 32'(cmd_err), 32'd1);
        nf_cmd_valid = 1'b0;
      end
      if (inject && i == 0) begin
        nf_cmd_valid = 1'b1; nf_cmd = 8'hFF; nf_addr_en = 1'b0;
        nf_column_addr = 32'hFFFF_FFFF; nf_row_addr = 32'hFFFF_FFFF;
        nf_total_cycle = 3'd7; nf_column_addr_cnt = 3'd4; nf_ceb = 4'h0;
      end
      @(negedge nfc_clk);
    end
  endtask

  task automatic done_phase(input string tag, input logic ac);
    check({tag, "_done"}, bus_vec(), mk_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ac, exp_ceb, 8'h00));
    check({tag, "_done_state"}, 32'(dbg_state), 32'(DONE));
    check({tag, "_done_err"}, 32'(cmd_err), 32'd0);
    @(negedge nfc_clk);
    check_idle({tag, "_after"});
  endtask

  initial begin
    rst_nfc = 1'b1; nf_cmd = 8'h00; nf_cmd_valid = 1'b0; nf_addr_en = 1'b0; nf_ceb = 4'h0;
    nf_total_cycle = 3'd0; nf_high_cycle = 4'd0; nf_column_addr_cnt = 3'd0; nf_row_addr_cnt = 3'd0;
    nf_column_addr = 32'd0; nf_row_addr = 32'd0; exp_ceb = 4'hF;
    repeat (3) @(negedge nfc_clk);
    check_idle("reset");
    check("reset_err", 32'(cmd_err), 32'd0);
    rst_nfc = 1'b0;
    @(negedge nfc_clk);
    check_idle("idle");

    // Command only, shortest bus cycle; then a request in the clock DONE is left.
    start_cmd(8'h70, 1'b0, 4'b0000, 3'd0, 4'd1, 3'd2, 3'd2, 32'h1111_1111, 32'h2222_2222);
    bus_cycle("t1_cle", 1'b1, 1'b0, 8'h70, 2, 1, 1'b0);
    check("t1_done", bus_vec(), mk_vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 8'h00));
    nf_cmd = 8'h33; nf_cmd_valid = 1'b1;
    @(negedge nfc_clk);
    nf_cmd_valid = 1'b0;
    check("t1_late_err", 32'(cmd_err), 32'd1);
    check_idle("t1_late_ignored");
    @(negedge nfc_clk);
    check_idle("t1_still_idle");
    check("t1_err_clear", 32'(cmd_err), 32'd0);

    // Full command + 2 column + 3 row bytes, L=5 H=2.
    e0 = edge_cnt;
    start_cmd(8'h00, 1'b1, 4'b1110, 3'd3, 4'd2, 3'd2, 3'd3, 32'h0000_0800, 32'h0001_2345);
    bus_cycle("t2_cle", 1'b1, 1'b0, 8'h00, 5, 2, 1'b0);
    bus_cycle("t2_col0", 1'b0, 1'b1, 8'h00, 5, 2, 1'b0);
    bus_cycle("t2_col1", 1'b0, 1'b1, 8'h08, 5, 2, 1'b0);
    bus_cycle("t2_row0", 1'b0, 1'b1, 8'h45, 5, 2, 1'b0);
    bus_cycle("t2_row1", 1'b0, 1'b1, 8'h23, 5, 2, 1'b0);
    bus_cycle("t2_row2", 1'b0, 1'b1, 8'h01, 5, 2, 1'b0);
    check("t2_latency", 32'(edge_cnt - e0), 32'd31);
    done_phase("t2", 1'b1);

    // Column count 7 clamps to 4 bytes; row count 0 skips ROW.
    start_cmd(8'h05, 1'b1, 4'b1101, 3'd0, 4'd1, 3'd7, 3'd0, 32'hA1B2_C3D4, 32'h5555_5555);
    bus_cycle("t3_cle", 1'b1, 1'b0, 8'h05, 2, 1, 1'b0);
    bus_cycle("t3_col0", 1'b0, 1'b1, 8'hD4, 2, 1, 1'b0);
    bus_cycle("t3_col1", 1'b0, 1'b1, 8'hC3, 2, 1, 1'b0);
    bus_cycle("t3_col2", 1'b0, 1'b1, 8'hB2, 2, 1, 1'b0);
    bus_cycle("t3_col3", 1'b0, 1'b1, 8'hA1, 2, 1, 1'b0);
    done_phase("t3", 1'b1);

    // Second request plus SFR rewrite mid-sequence must not disturb the snapshot.
    start_cmd(8'h80, 1'b1, 4'b1011, 3'd1, 4'd1, 3'd2, 3'd1, 32'h0000_1234, 32'h0000_0056);
    bus_cycle("t4_cle", 1'b1, 1'b0, 8'h80, 3, 1, 1'b1);
    bus_cycle("t4_col0", 1'b0, 1'b1, 8'h34, 3, 1, 1'b0);
    bus_cycle("t4_col1", 1'b0, 1'b1, 8'h12, 3, 1, 1'b0);
    bus_cycle("t4_row0", 1'b0, 1'b1, 8'h56, 3, 1, 1'b0);
    done_phase("t4", 1'b1);

    // Reset during ROW aborts without addr_clear.
    start_cmd(8'h60, 1'b1, 4'b0111, 3'd0, 4'd1, 3'd0, 3'd3, 32'h0, 32'h00AB_CDEF);
    bus_cycle("t5_cle", 1'b1, 1'b0, 8'h60, 2, 1, 1'b0);
    check("t5_row0", bus_vec(), mk_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0111, 8'hEF));
    check("t5_row_state", 32'(dbg_state), 32'(ROW));
    rst_nfc = 1'b1;
    @(negedge nfc_clk);
    check_idle("t5_rst");
    rst_nfc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge nfc_clk);
      check("t5_no_clear", 32'({addr_clear, seq_busy}), 32'd0);
    end

    // Fresh command after the abort; high=15 clamps to H=L-1=2 with L=3.
    start_cmd(8'h90, 1'b0, 4'b1100, 3'd1, 4'd15, 3'd0, 3'd0, 32'h0, 32'h0);
    bus_cycle("t6_cle", 1'b1, 1'b0, 8'h90, 3, 2, 1'b0);
    done_phase("t6", 1'b0);

    // high=0 clamps to H=1 with L=4.
    start_cmd(8'hA5, 1'b0, 4'b0110, 3'd2, 4'd0, 3'd0, 3'd0, 32'h0, 32'h0);
    bus_cycle("t7_cle", 1'b1, 1'b0, 8'hA5, 4, 1, 1'b0);
    done_phase("t7", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
